// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes,
// FSM state encodings, datapath select encodings and the control word.
package mips_pkg;

   // Opcodes (instr[31:26]) understood by the controller
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // FSM states; encodings 14 and 15 are unused and recover to FETCH
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ANDIEX = 4'd10,
      S_LUIEX  = 4'd11,
      S_IWB    = 4'd12,
      S_JUMP   = 4'd13
   } state_t;

   // ALU source B select
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   // Immediate extension select
   localparam logic [1:0] IMM_SIGN  = 2'b00;
   localparam logic [1:0] IMM_ZERO  = 2'b01;
   localparam logic [1:0] IMM_UPPER = 2'b10;

   // ALU operation class
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   // PC source select
   localparam logic [1:0] PC_ALURES = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Raw per-state control word; the top gates write enables with
   // mem_ready and reset before they leave the block.
   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       irwrite;
      logic       iord;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immsrc;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
   } ctrl_t;

   // True for every opcode DECODE can dispatch
   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI,
         OP_LUI, OP_LW, OP_SW: is_legal_op = 1'b1;
         default:              is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational state -> control word table (Moore outputs).
// Anything not set for a state stays 0, including unused encodings.
module mc_ctrl_rom
   import mips_pkg::*;
(
   input  state_t state_i,
   output ctrl_t  ctrl_o
);

   // Table lookup with all-zero default
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.alusrcb = SRCB_FOUR;
            ctrl_o.irwrite = 1'b1;
            ctrl_o.pcwrite = 1'b1;
         end
         S_DECODE: begin
            ctrl_o.alusrcb = SRCB_IMM4;
            ctrl_o.immsrc  = IMM_SIGN;
         end
         S_MEMADR: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.immsrc  = IMM_SIGN;
         end
         S_MEMRD: begin
            ctrl_o.iord = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.iord     = 1'b1;
            ctrl_o.memwrite = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl_o.regdst   = 1'b1;
            ctrl_o.regwrite = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.aluop   = ALU_SUB;
            ctrl_o.pcsrc   = PC_ALUOUT;
            ctrl_o.branch  = 1'b1;
         end
         S_ADDIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.immsrc  = IMM_SIGN;
         end
         S_ANDIEX: begin
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.immsrc  = IMM_ZERO;
            ctrl_o.aluop   = ALU_AND;
         end
         S_LUIEX: begin
            // rs is $0 for lui, so A + (imm<<16) is the result
            ctrl_o.alusrca = 1'b1;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.immsrc  = IMM_UPPER;
            ctrl_o.aluop   = ALU_ADD;
         end
         S_IWB: begin
            ctrl_o.regwrite = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pcsrc   = PC_JUMP;
            ctrl_o.pcwrite = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller. Holds the FSM state register, the
// next-state logic, mem_ready gating of FETCH, the retired-instruction
// counter and the illegal-opcode pulse. state_o exposes the FSM state.
module mc_maindec
   import mips_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter bit USE_MRDY = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcen,
   output logic             irwrite,
   output logic             iord,
   output logic             memwrite,
   output logic             regwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       immsrc,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic [CNT_W-1:0] instret,
   output logic             illegal_op,
   output logic [3:0]       state_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             illegal_q, illegal_d;
   logic             mrdy;
   logic             mem_gate;
   ctrl_t            ctrl;

   // With USE_MRDY=0 every memory state completes in one cycle
   assign mrdy = USE_MRDY ? mem_ready : 1'b1;

   mc_ctrl_rom u_rom (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   // State, counter and illegal-pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state; op comes straight from the IR, which is stable after FETCH
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mrdy) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ANDI:      state_d = S_ANDIEX;
               OP_LUI:       state_d = S_LUIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD:  if (mrdy) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mrdy) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_IWB;
         S_ANDIEX: state_d = S_IWB;
         S_LUIEX:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Retire count on every entry into FETCH; illegal pulse follows DECODE
   always_comb begin
      instret_d = instret_q;
      if ((state_d == S_FETCH) && (state_q != S_FETCH))
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      illegal_d = (state_q == S_DECODE) && !is_legal_op(op);
   end

   // Output gating: FETCH writes wait on memory, reset kills all strobes
   always_comb begin
      mem_gate = (state_q == S_FETCH) ? mrdy : 1'b1;
      pcen     = ~reset & ((ctrl.pcwrite & mem_gate) | (ctrl.branch & zero));
      irwrite  = ~reset & ctrl.irwrite & mem_gate;
      memwrite = ~reset & ctrl.memwrite;
      regwrite = ~reset & ctrl.regwrite;
      iord     = ctrl.iord;
      regdst   = ctrl.regdst;
      memtoreg = ctrl.memtoreg;
      alusrca  = ctrl.alusrca;
      alusrcb  = ctrl.alusrcb;
      immsrc   = ctrl.immsrc;
      aluop    = ctrl.aluop;
      pcsrc    = ctrl.pcsrc;
   end

   assign instret    = instret_q;
   assign illegal_op = illegal_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Randomized bench for mc_maindec. A queue-based model expands each
// decoded instruction into its list of expected steps and checks every
// output each cycle, including random resets and a narrow retire counter
// so the wrap is exercised.
module tb_mc_maindec;
   import mips_pkg::*;

   localparam int CNT_W  = 4;
   localparam int CYCLES = 4000;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0]       alusrcb, immsrc, aluop, pcsrc;
   logic [CNT_W-1:0] instret;
   logic             illegal_op;
   logic [3:0]       state_o;

   mc_maindec #(.CNT_W(CNT_W), .USE_MRDY(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .iord       (iord),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .immsrc     (immsrc),
      .aluop      (aluop),
      .pcsrc      (pcsrc),
      .instret    (instret),
      .illegal_op (illegal_op),
      .state_o    (state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // One expected step of an instruction. mem marks a step that repeats
   // until mem_ready; its pcwrite/irwrite only fire on the ready cycle.
   typedef struct packed {
      logic [3:0] st;
      logic       pcwrite, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
      logic [1:0] alusrcb, immsrc, aluop, pcsrc;
      logic       branch, mem;
   } step_t;

   step_t            exp_q[$];
   logic [CNT_W-1:0] exp_retired;
   logic             exp_illegal;
   int               n_cmp = 0;
   int               n_err = 0;

   logic [5:0] legal_ops [8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0C, 6'h0F, 6'h02};

   // scoreboard check
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] st, input logic pw, irw, io, mw, rw, rd, m2r, asa,
                       input logic [1:0] srcb, imm, aop, pcs, input logic br, mem);
      step_t s;
      s = '{st, pw, irw, io, mw, rw, rd, m2r, asa, srcb, imm, aop, pcs, br, mem};
      exp_q.push_back(s);
   endtask

   task automatic push_fetch();
      push(S_FETCH, 1,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1);
   endtask

   function automatic logic tb_legal(input logic [5:0] o);
      tb_legal = 1'b0;
      for (int i = 0; i < 8; i++) if (legal_ops[i] == o) tb_legal = 1'b1;
   endfunction

   // Steps that follow DECODE for a given opcode
   task automatic push_instr(input logic [5:0] o);
      case (o)
         6'h23: begin
            push(S_MEMADR, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
            push(S_MEMRD,  0,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
            push(S_MEMWB,  0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         end
         6'h2B: begin
            push(S_MEMADR, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
            push(S_MEMWR,  0,0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
         end
         6'h00: begin
            push(S_EXEC,   0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0);
            push(S_ALUWB,  0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         end
         6'h04: push(S_BRANCH, 0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0);
         6'h08: begin
            push(S_ADDIEX, 0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0);
            push(S_IWB,    0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         end
         6'h0C: begin
            push(S_ANDIEX, 0,0,0,0,0,0,0,1, 2'b10, 2'b01, 2'b11, 2'b00, 0, 0);
            push(S_IWB,    0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         end
         6'h0F: begin
            push(S_LUIEX,  0,0,0,0,0,0,0,1, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0);
            push(S_IWB,    0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
         end
         6'h02: push(S_JUMP, 1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0);
         default: ;
      endcase
   endtask

   task automatic model_reset();
      exp_q.delete();
      push_fetch();
      exp_retired = '0;
      exp_illegal = 1'b0;
   endtask

   // Compare all outputs against the head step, then advance the model
   task automatic check_and_step();
      step_t      s;
      logic       gate, e_pcen, e_ir, e_mw, e_rw, nxt_illegal;
      logic [15:0] obs_v, exp_v;
      s      = exp_q[0];
      gate   = s.mem ? mem_ready : 1'b1;
      e_pcen = (s.pcwrite & gate) | (s.branch & zero);
      e_ir   = s.irwrite & gate;
      e_mw   = s.memwrite;
      e_rw   = s.regwrite;
      if (reset) begin
         e_pcen = 1'b0; e_ir = 1'b0; e_mw = 1'b0; e_rw = 1'b0;
      end
      obs_v = {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, immsrc, aluop, pcsrc};
      exp_v = {e_pcen, e_ir, s.iord, e_mw, e_rw, s.regdst, s.memtoreg, s.alusrca,
               s.alusrcb, s.immsrc, s.aluop, s.pcsrc};
      check("ctrl", 32'(obs_v), 32'(exp_v));
      check("state", 32'(state_o), 32'(s.st));
      check("instret", 32'(instret), 32'(exp_retired));
      check("illegal_op", 32'(illegal_op), 32'(exp_illegal));

      if (reset) return;
      nxt_illegal = 1'b0;
      if (!(s.mem && !mem_ready)) begin
         void'(exp_q.pop_front());
         if (s.st == 4'(S_FETCH)) begin
            push(S_DECODE, 0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0);
         end else if (s.st == 4'(S_DECODE)) begin
            push_instr(op);
            nxt_illegal = !tb_legal(op);
         end
         if (exp_q.size() == 0) begin
            exp_retired = exp_retired + 1'b1;
            push_fetch();
         end
      end
      exp_illegal = nxt_illegal;
   endtask

   // driver: random op (only while fetching), mem_ready, zero and resets
   task automatic drive();
      int rst_odds;
      if (reset) begin
         if ($urandom_range(0, 1) == 0) reset = 1'b0;
      end else begin
         rst_odds = (exp_q[0].st == 4'(S_MEMWR)) ? 6 : 150;
         if ($urandom_range(0, rst_odds - 1) == 0) begin
            reset = 1'b1;
            model_reset();
         end
      end
      if (exp_q[0].st == 4'(S_FETCH)) begin
         if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
         else begin
            op = 6'($urandom_range(0, 63));
            while (tb_legal(op)) op = 6'($urandom_range(0, 63));
         end
      end
      mem_ready = ($urandom_range(0, 9) < 6);
      zero      = 1'($urandom_range(0, 1));
   endtask

   initial begin
      reset     = 1'b1;
      op        = 6'h00;
      zero      = 1'b0;
      mem_ready = 1'b0;
      model_reset();
      for (int c = 0; c < CYCLES; c++) begin
         @(negedge clk);
         check_and_step();
         @(posedge clk);
         #1;
         drive();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
